// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and state encoding for the mux4to1 round-robin arbiter.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
interface mux4_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               busy;

    modport master (output req, input gnt, input sel, input busy);
    modport slave  (input req, output gnt, output sel, output busy);

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first set bit of req & mask from ptr upward.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   pos;

    always_comb begin
        cand  = req & mask;
        valid = 1'b0;
        idx   = ptr;
        pos   = ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // 2-bit add wraps naturally, giving the mod-4 rotation
            pos = ptr + SEL_W'(i);
            if (!valid && cand[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the shared mux4to1: registered one-hot gnt, sel and busy,
// with optional forced rotation after MAX_HOLD consecutive grant cycles.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    mux4_rr_arbiter_if.slave  arb
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic               own_req;
    logic               others_pending;
    logic               hold_expired;

    // While granted, the picker only runs for a handover or preemption,
    // so the owner's bit can always be masked in that state.
    assign pick_mask = (state_q == ARB_GRANT) ? ~gnt_q : '1;

    rr_pick4 u_pick (
        .req   (arb.req),
        .mask  (pick_mask),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        own_req        = arb.req[sel_q];
        others_pending = |(arb.req & ~gnt_q);
        hold_expired   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX);

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d    = ARB_GRANT;
                    gnt_d      = NUM_REQ'(1) << pick_idx;
                    sel_d      = pick_idx;
                    busy_d     = 1'b1;
                    ptr_d      = pick_idx + SEL_W'(1);
                    hold_cnt_d = HOLD_W'(1);
                end
            end
            ARB_GRANT: begin
                if (!own_req || (hold_expired && others_pending)) begin
                    if (pick_valid) begin
                        gnt_d      = NUM_REQ'(1) << pick_idx;
                        sel_d      = pick_idx;
                        ptr_d      = pick_idx + SEL_W'(1);
                        hold_cnt_d = HOLD_W'(1);
                    end else begin
                        // sel intentionally keeps the last owner's index
                        state_d    = ARB_IDLE;
                        gnt_d      = '0;
                        busy_d     = 1'b0;
                        hold_cnt_d = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt_q < HOLD_MAX)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign arb.gnt  = gnt_q;
    assign arb.sel  = sel_q;
    assign arb.busy = busy_q;

endmodule
